mem_boot_loader: RTL

//  Hardware program loader for the pipelined processor. Accepts a framed word stream over a

---
 rtl/mem_boot_loader.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/mem_boot_loader.sv
// rtl/mem_boot_loader.sv - framed stream program loader with checksum; optional LOADER_CLEAR_EN pre-clear
module mem_boot_loader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              ext_valid,
  input  logic [DATA_W-1:0] ext_data,
  output logic              ext_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst_n,
  output logic              busy,
  output logic              err
);

  typedef enum logic [2:0] {
    S_CLEAR, S_HDR_A, S_HDR_L, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

`ifdef LOADER_CLEAR_EN
  localparam state_t S_INIT = S_CLEAR;
`else
  localparam state_t S_INIT = S_HDR_A;
`endif

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t              state, state_next;
  logic [ADDR_W-1:0]   ptr;
  logic [DATA_W-1:0]   len;
  logic [DATA_W-1:0]   cnt;
  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   sum_next;
  logic                beat;

  // Reduce an arbitrary address into 0..DEPTH-1 (DEPTH need not be a power of two).
  function automatic logic [ADDR_W-1:0] wrap_addr(input logic [ADDR_W-1:0] a);
    return ADDR_W'(32'(a) % DEPTH);
  endfunction

  // Advance the write pointer, wrapping from the last word back to 0.
  function automatic logic [ADDR_W-1:0] next_ptr(input logic [ADDR_W-1:0] p);
    return (p == LAST_ADDR) ? '0 : p + 1'b1;
  endfunction

  assign beat     = ext_valid & ext_ready;
  assign sum_next = sum + ext_data;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_INIT;
    else      state <= state_next;
  end

  // Next-state decode plus the handshake and busy outputs, which depend only on state.
  always_comb begin
    state_next = state;
    ext_ready  = 1'b0;
    busy       = 1'b1;
    case (state)
`ifdef LOADER_CLEAR_EN
      S_CLEAR: if (ptr == LAST_ADDR) state_next = S_HDR_A;
`endif
      S_HDR_A: begin
        ext_ready = 1'b1;
        if (beat) state_next = S_HDR_L;
      end
      S_HDR_L: begin
        ext_ready = 1'b1;
        if (beat) state_next = S_DATA;
      end
      S_DATA: begin
        ext_ready = 1'b1;
        if (beat && cnt == len) state_next = S_CHK;
      end
      S_CHK: begin
        ext_ready = 1'b1;
        if (beat) state_next = (sum_next == '0) ? S_DONE : S_ERR;
      end
      S_DONE, S_ERR: begin
        busy = 1'b0;
        if (start) state_next = S_INIT;
      end
      default: state_next = S_INIT;
    endcase
  end

  // Datapath: header capture, registered memory writes, running checksum and core reset control.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      len       <= '0;
      cnt       <= '0;
      sum       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_rst_n <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      case (state)
`ifdef LOADER_CLEAR_EN
        S_CLEAR: begin
          mem_we    <= 1'b1;
          mem_addr  <= ptr;
          mem_wdata <= '0;
          ptr       <= next_ptr(ptr);
        end
`endif
        S_HDR_A: if (beat) begin
          ptr <= wrap_addr(ext_data[ADDR_W-1:0]);
          sum <= sum_next;
        end
        S_HDR_L: if (beat) begin
          len <= ext_data;
          sum <= sum_next;
        end
        S_DATA: if (beat) begin
          mem_we    <= 1'b1;
          mem_addr  <= ptr;
          mem_wdata <= ext_data;
          ptr       <= next_ptr(ptr);
          cnt       <= cnt + 1'b1;
          sum       <= sum_next;
        end
        S_CHK: if (beat) begin
          cpu_rst_n <= (sum_next == '0);
          err       <= (sum_next != '0);
        end
        S_DONE, S_ERR: if (start) begin
          cpu_rst_n <= 1'b0;
          err       <= 1'b0;
          sum       <= '0;
          cnt       <= '0;
          ptr       <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
